dds_phase_accumulator: RTL and testbench

//  Numerically-controlled phase generator that drives the DDS sine lookup stage.

---
 rtl/dds_pkg.sv | 26 ++
 rtl/sample_tick_gen.sv | 32 +++
 rtl/dds_phase_accumulator.sv | 115 +++++++++++
 tb/tb_dds_phase_accumulator.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase path: default widths and the
// layout of the {neg, inv, addr, cntr} phase word handed to the sine lookup.
package dds_pkg;

    localparam int ADDR_WDTH_DEF = 12;
    localparam int CNTR_WDTH_DEF = 4;
    localparam int ACC_WDTH_DEF  = 32;

    localparam int PHASE_WDTH = ADDR_WDTH_DEF + CNTR_WDTH_DEF;

    // Field positions within the default-width phase word, MSB to LSB
    localparam int NEG_BIT  = PHASE_WDTH - 1;
    localparam int INV_BIT  = PHASE_WDTH - 2;
    localparam int ADDR_MSB = PHASE_WDTH - 3;
    localparam int ADDR_LSB = CNTR_WDTH_DEF;
    localparam int CNTR_MSB = CNTR_WDTH_DEF - 1;
    localparam int CNTR_LSB = 0;

    typedef struct packed {
        logic                         neg;
        logic                         inv;
        logic [ADDR_MSB-ADDR_LSB:0]   addr;
        logic [CNTR_MSB-CNTR_LSB:0]   cntr;
    } phase_word_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts clk cycles while enabled and emits a one-cycle
// tick on the last count of every SAMPLE_DIV-cycle period.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] r_div_cnt;

    assign o_tick = i_enable && (r_div_cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_div_cnt <= '0;
        end else if (i_enable) begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: adds the active tuning word once per sample tick and
// presents the truncated phase word plus strobes aligned to it and to the lookup.
module dds_phase_accumulator
    import dds_pkg::*;
#(
    parameter int                  ADDR_WDTH  = ADDR_WDTH_DEF,
    parameter int                  CNTR_WDTH  = CNTR_WDTH_DEF,
    parameter int                  ACC_WDTH   = ACC_WDTH_DEF,
    parameter int                  SAMPLE_DIV = 256,
    parameter int                  LOOKUP_LAT = 1,
    parameter logic [ACC_WDTH-1:0] FTW_RESET  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           phase_clear,
    input  logic [ACC_WDTH-1:0]            tune_word,
    input  logic                           tune_valid,
    output logic                           tune_ready,
    output logic [ADDR_WDTH+CNTR_WDTH-1:0] sine_lookup,
    output logic                           phase_strobe,
    output logic                           value_valid
);

    localparam int PW = ADDR_WDTH + CNTR_WDTH;

    logic                w_tick;
    logic                w_sample;
    logic                w_accept;
    logic [ACC_WDTH-1:0] w_acc_next;

    logic [ACC_WDTH-1:0] r_acc;
    logic [ACC_WDTH-1:0] r_ftw_active;
    logic [ACC_WDTH-1:0] r_pend;
    logic                r_pend_full;
    logic [PW-1:0]       r_phase_word;
    logic                r_strobe;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .i_enable (enable),
        .i_clear  (phase_clear),
        .o_tick   (w_tick)
    );

    // A phase clear swallows a coincident tick entirely, including the FTW swap
    assign w_sample   = w_tick && !phase_clear;
    assign w_accept   = tune_valid && !r_pend_full;
    assign w_acc_next = r_acc + r_ftw_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_phase_word <= '0;
            r_strobe     <= 1'b0;
        end else begin
            r_strobe <= w_sample;
            if (phase_clear) begin
                r_acc        <= '0;
                r_phase_word <= '0;
            end else if (w_sample) begin
                r_acc        <= w_acc_next;
                r_phase_word <= w_acc_next[ACC_WDTH-1 -: PW];
            end
        end
    end

    // The tick that drains pending still accumulates with the old active word.
    // Accept needs pend empty and drain needs pend full, so they never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ftw_active <= FTW_RESET;
            // NOTE: the pending data word is reset too so a discarded FTW can
            // never reappear; it is a single register, not a memory.
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
        end else if (w_sample && r_pend_full) begin
            r_ftw_active <= r_pend;
            r_pend_full  <= 1'b0;
        end else if (w_accept) begin
            r_pend       <= tune_word;
            r_pend_full  <= 1'b1;
        end
    end

    generate
        if (LOOKUP_LAT == 0) begin : g_no_lat
            assign value_valid = r_strobe;
        end else begin : g_lat
            logic [LOOKUP_LAT-1:0] r_vv_pipe;

            // Only rst flushes the delay line; phase_clear leaves in-flight strobes alone
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vv_pipe <= '0;
                end else begin
                    r_vv_pipe[0] <= r_strobe;
                    for (int i = 1; i < LOOKUP_LAT; i++) begin
                        r_vv_pipe[i] <= r_vv_pipe[i-1];
                    end
                end
            end

            assign value_valid = r_vv_pipe[LOOKUP_LAT-1];
        end
    endgenerate

    assign tune_ready   = !r_pend_full;
    assign sine_lookup  = r_phase_word;
    assign phase_strobe = r_strobe;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Self-checking bench for dds_phase_accumulator: directed scenarios plus random
// traffic, all compared against a behavioural phase model kept in the bench.
module tb_dds_phase_accumulator;
    import dds_pkg::*;

    localparam int          DIV     = 4;
    localparam int          LAT     = 2;
    localparam logic [31:0] FTW_RST = 32'h1000_0000;
    localparam int          SHIFT   = ACC_WDTH_DEF - PHASE_WDTH;

    logic                  clk         = 1'b0;
    logic                  rst         = 1'b0;
    logic                  enable      = 1'b0;
    logic                  phase_clear = 1'b0;
    logic                  tune_valid  = 1'b0;
    logic [31:0]           tune_word   = '0;
    logic                  tune_ready;
    logic [PHASE_WDTH-1:0] sine_lookup;
    logic                  phase_strobe;
    logic                  value_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dds_phase_accumulator #(
        .ADDR_WDTH  (ADDR_WDTH_DEF),
        .CNTR_WDTH  (CNTR_WDTH_DEF),
        .ACC_WDTH   (ACC_WDTH_DEF),
        .SAMPLE_DIV (DIV),
        .LOOKUP_LAT (LAT),
        .FTW_RESET  (FTW_RST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .phase_clear  (phase_clear),
        .tune_word    (tune_word),
        .tune_valid   (tune_valid),
        .tune_ready   (tune_ready),
        .sine_lookup  (sine_lookup),
        .phase_strobe (phase_strobe),
        .value_valid  (value_valid)
    );

    // Behavioural model: phase as a plain 32-bit number, sample period counted
    // in clocks, strobe history kept as a queue (oldest first, newest last).
    logic [31:0]           m_acc;
    logic [31:0]           m_ftw;
    logic [31:0]           m_pend;
    bit                    m_full;
    int                    m_div;
    logic [PHASE_WDTH-1:0] m_sine;
    bit                    m_sq[$];
    bit                    m_tick;
    bit                    m_accept;
    bit                    m_new_strobe;
    phase_word_t           m_pw;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc  = '0;
            m_ftw  = FTW_RST;
            m_pend = '0;
            m_full = 1'b0;
            m_div  = 0;
            m_sine = '0;
            m_sq.delete();
            repeat (LAT + 1) m_sq.push_back(1'b0);
        end else begin
            m_accept     = tune_valid && !m_full;
            m_tick       = enable && (m_div == DIV - 1);
            m_new_strobe = 1'b0;
            if (phase_clear) begin
                m_acc  = '0;
                m_div  = 0;
                m_sine = '0;
            end else begin
                if (enable) m_div = (m_div + 1) % DIV;
                if (m_tick) begin
                    m_acc       = m_acc + m_ftw;
                    m_pw.neg    = m_acc[SHIFT + NEG_BIT];
                    m_pw.inv    = m_acc[SHIFT + INV_BIT];
                    m_pw.addr   = m_acc[SHIFT + ADDR_MSB -: ADDR_MSB - ADDR_LSB + 1];
                    m_pw.cntr   = m_acc[SHIFT + CNTR_MSB -: CNTR_MSB - CNTR_LSB + 1];
                    m_sine      = m_pw;
                    m_new_strobe = 1'b1;
                    if (m_full) begin
                        m_ftw  = m_pend;
                        m_full = 1'b0;
                    end
                end
            end
            if (m_accept) begin
                m_pend = tune_word;
                m_full = 1'b1;
            end
            m_sq.push_back(m_new_strobe);
            void'(m_sq.pop_front());
        end
    end

    // One clock step; all outputs compared against the model on the falling edge
    task automatic advance(input string tag);
        @(negedge clk);
        checks++;
        if (sine_lookup !== m_sine || phase_strobe !== m_sq[LAT] ||
            value_valid !== m_sq[0] || tune_ready !== !m_full) begin
            errors++;
            $display("FAIL %s model: got sine=%h strobe=%b vv=%b ready=%b, want sine=%h strobe=%b vv=%b ready=%b",
                     tag, sine_lookup, phase_strobe, value_valid, tune_ready,
                     m_sine, m_sq[LAT], m_sq[0], !m_full);
        end
    endtask

    task automatic wait_strobe(input string tag, output int n);
        n = 0;
        do begin
            advance(tag);
            n++;
        end while (phase_strobe !== 1'b1 && n < 4 * DIV + 12);
        checks++;
        if (phase_strobe !== 1'b1) begin
            errors++;
            $display("FAIL %s strobe_timeout: no phase_strobe within %0d clk", tag, n);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sine_lookup !== '0 || phase_strobe !== 1'b0 || value_valid !== 1'b0 || tune_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got sine=%h strobe=%b vv=%b ready=%b, want 0000 0 0 1",
                     sine_lookup, phase_strobe, value_valid, tune_ready);
        end
        rst    = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_freerun();
        int n;
        logic [15:0] exp;
        for (int k = 1; k <= 16; k++) begin
            wait_strobe("freerun", n);
            exp = 16'(k * 32'h1000);
            checks++;
            if (sine_lookup !== exp || n != DIV) begin
                errors++;
                $display("FAIL freerun_step%0d: got sine=%h after %0d clk, want %h after %0d clk",
                         k, sine_lookup, n, exp, DIV);
            end
        end
    endtask

    task automatic test_tune();
        int n;
        tune_word  = 32'h2000_0000;
        tune_valid = 1'b1;
        advance("tune");
        tune_valid = 1'b0;
        checks++;
        if (tune_ready !== 1'b0) begin
            errors++;
            $display("FAIL tune_ready_drop: got %b, want 0", tune_ready);
        end
        wait_strobe("tune", n);
        checks++;
        if (sine_lookup !== 16'h1000 || tune_ready !== 1'b1 || n != DIV - 1) begin
            errors++;
            $display("FAIL tune_old_ftw: got sine=%h ready=%b n=%0d, want 1000 1 %0d",
                     sine_lookup, tune_ready, n, DIV - 1);
        end
        wait_strobe("tune", n);
        checks++;
        if (sine_lookup !== 16'h3000) begin
            errors++;
            $display("FAIL tune_new_ftw1: got sine=%h, want 3000", sine_lookup);
        end
        wait_strobe("tune", n);
        checks++;
        if (sine_lookup !== 16'h5000) begin
            errors++;
            $display("FAIL tune_new_ftw2: got sine=%h, want 5000", sine_lookup);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        tune_word  = 32'h3000_0000;
        tune_valid = 1'b1;
        advance("b2b");
        tune_word  = 32'h0800_0000;
        checks++;
        if (tune_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_blocked: got ready=%b, want 0", tune_ready);
        end
        wait_strobe("b2b", n);
        checks++;
        if (sine_lookup !== 16'h7000 || tune_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain: got sine=%h ready=%b, want 7000 1", sine_lookup, tune_ready);
        end
        advance("b2b");
        tune_valid = 1'b0;
        checks++;
        if (tune_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: got ready=%b, want 0", tune_ready);
        end
        wait_strobe("b2b", n);
        checks++;
        if (sine_lookup !== 16'hA000) begin
            errors++;
            $display("FAIL b2b_first_word: got sine=%h, want a000", sine_lookup);
        end
        wait_strobe("b2b", n);
        checks++;
        if (sine_lookup !== 16'hA800 || n != DIV) begin
            errors++;
            $display("FAIL b2b_second_word: got sine=%h n=%0d, want a800 %0d", sine_lookup, n, DIV);
        end
    endtask

    task automatic test_clear_on_tick();
        int n;
        repeat (DIV - 1) advance("clear");
        phase_clear = 1'b1;
        advance("clear");
        phase_clear = 1'b0;
        checks++;
        if (sine_lookup !== '0 || phase_strobe !== 1'b0) begin
            errors++;
            $display("FAIL clear_override: got sine=%h strobe=%b, want 0000 0", sine_lookup, phase_strobe);
        end
        wait_strobe("clear", n);
        checks++;
        if (sine_lookup !== 16'h0800 || n != DIV) begin
            errors++;
            $display("FAIL clear_restart: got sine=%h n=%0d, want 0800 %0d", sine_lookup, n, DIV);
        end
    endtask

    task automatic test_enable_hold();
        int n;
        advance("hold");
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            advance("hold");
            checks++;
            if (phase_strobe !== 1'b0 || sine_lookup !== 16'h0800) begin
                errors++;
                $display("FAIL hold_cycle%0d: got sine=%h strobe=%b, want 0800 0", i, sine_lookup, phase_strobe);
            end
        end
        enable = 1'b1;
        wait_strobe("hold", n);
        checks++;
        if (sine_lookup !== 16'h1000 || n != DIV - 1) begin
            errors++;
            $display("FAIL hold_resume: got sine=%h n=%0d, want 1000 %0d", sine_lookup, n, DIV - 1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [15:0] exp;
        tune_word  = 32'h4000_0000;
        tune_valid = 1'b1;
        advance("rstmid");
        tune_valid = 1'b0;
        advance("rstmid");
        checks++;
        if (tune_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pending: got ready=%b, want 0", tune_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sine_lookup !== '0 || phase_strobe !== 1'b0 || value_valid !== 1'b0 || tune_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_immediate: got sine=%h strobe=%b vv=%b ready=%b, want 0000 0 0 1",
                     sine_lookup, phase_strobe, value_valid, tune_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            wait_strobe("rstmid", n);
            exp = 16'(k * 32'h1000);
            checks++;
            if (sine_lookup !== exp || n != DIV) begin
                errors++;
                $display("FAIL rstmid_ftw_reset%0d: got sine=%h n=%0d, want %h %0d", k, sine_lookup, n, exp, DIV);
            end
        end
        advance("rstmid");
        checks++;
        if (value_valid !== 1'b0) begin
            errors++;
            $display("FAIL vv_early: got value_valid=%b one clk after strobe, want 0", value_valid);
        end
        advance("rstmid");
        checks++;
        if (value_valid !== 1'b1) begin
            errors++;
            $display("FAIL vv_latency: got value_valid=%b %0d clk after strobe, want 1", value_valid, LAT);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            enable      = ($urandom_range(7) != 0);
            phase_clear = ($urandom_range(15) == 0);
            tune_valid  = ($urandom_range(3) == 0);
            tune_word   = $urandom();
            advance("random");
        end
        enable      = 1'b1;
        phase_clear = 1'b0;
        tune_valid  = 1'b0;
        repeat (2 * DIV) advance("random_tail");
    endtask

    initial begin
        test_reset();
        test_freerun();
        test_tune();
        test_back_to_back();
        test_clear_on_tick();
        test_enable_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
